rgmii_tx_nibble_if: RTL and testbench
=====================================

Name: rgmii_tx_nibble_if

Overview:
Downstream neighbour of the TX MAC. Consumes the MAC's byte-wide RGMII-side stream (data, dv, er) and drives rgmii_mac_tx_rdy back to it. Produces per-edge nibble and control signals for the external DDR output registers.
- Gigabit mode: full byte every cycle.
- MII mode (10/100): one byte every two cycles, low nibble first.

Parameters:
DATA_WIDTH, 8, MAC-side byte width; fixed at 8, other values unsupported.
NIB_WIDTH, 4, RGMII data pins per edge; fixed at 4.

Ports:
clk  input  1  TX clock; single clock domain.
reset_n  input  1  synchronous reset, active-low.
rgmii_mac_tx_data  input  8  byte from TX MAC.
rgmii_mac_tx_dv  input  1  byte valid from TX MAC.
rgmii_mac_tx_er  input  1  byte error from TX MAC.
mii_select  input  1  0 = gigabit RGMII (DDR), 1 = MII 10/100 (SDR nibbles).
rgmii_mac_tx_rdy  output  1  block accepts the presented byte this cycle.
rgmii_txd_rise  output  4  nibble for rising-edge DDR register.
rgmii_txd_fall  output  4  nibble for falling-edge DDR register.
rgmii_tx_ctl_rise  output  1  TX_CTL rising edge = TX_EN.
rgmii_tx_ctl_fall  output  1  TX_CTL falling edge = TX_EN xor TX_ER.

Behaviour:
- Reset (reset_n low at posedge clk):
  - All outputs 0, including rdy.
  - FSM to IDLE; mode register cleared to gigabit.
  - rdy rises on the first clock after reset_n is sampled high.
- Mode register:
  - Loads mii_select only when FSM is in IDLE and rgmii_mac_tx_dv = 0.
  - Otherwise holds, so a mid-frame mode change takes effect at the next idle.
- A byte is accepted on a posedge where rdy = 1 and dv = 1; the byte is captured into hold_data/hold_er.
- FSM states: IDLE, GIG, MII_LO, MII_HI.
- Gigabit mode:
  - rdy held 1 outside reset.
  - FSM IDLE <-> GIG, following dv.
  - Each cycle, registered with latency 1: txd_rise <= data[3:0], txd_fall <= data[7:4], ctl_rise <= dv, ctl_fall <= dv ^ er.
  - When dv = 0, data outputs are 0.
  - er with dv = 0 is passed as ctl_fall = 1 (carrier extend / error signalling); data 0.
- MII mode:
  - IDLE, rdy = 1:
    - dv = 1: capture byte, go to MII_LO.
    - dv = 0: outputs idle (all 0).
  - MII_LO, rdy = 0:
    - txd_rise = txd_fall = hold_data[3:0].
    - ctl_rise = 1, ctl_fall = 1 ^ hold_er.
    - Next state MII_HI.
  - MII_HI, rdy = 1:
    - txd_rise = txd_fall = hold_data[7:4]; ctl as in MII_LO.
    - If dv = 1: capture next byte, go to MII_LO (back-to-back, no gap nibble).
    - Else go to IDLE.
  - Result: one byte per 2 cycles; the rdy pulse pattern 1,0,1,0… lets the MAC advance one byte per rising rdy edge.
  - Latency: low nibble appears 1 cycle after acceptance; high nibble 2 cycles after.
- dv dropping while in MII_LO: the captured byte still completes both nibbles. A frame never ends on half a byte.
- dv = 1 while rdy = 0 (MII_LO): not accepted. MAC must hold the byte; no data loss, no duplication.
- Reset mid-frame: immediate return to reset values on that edge. Partial nibble is dropped; the PHY sees TX_EN fall.

Optional Feature:
Macro RGMII_TX_STATS_EN.
- Defined: adds three outputs, all synchronously reset to 0 and wrapping on overflow.
  - stat_frame_cnt [31:0]: increments on the cycle an accepted frame ends (dv 1->0 at an acceptance point).
  - stat_byte_cnt [31:0]: increments once per accepted byte.
  - stat_err_cnt [15:0]: increments once per frame in which any accepted byte had er = 1.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: hold reset_n low 3 cycles with dv = 1, data = 8'hA5 -> all outputs 0, rdy 0; rdy = 1 on the first cycle after release.
- Gigabit frame: mii_select = 0, bytes 55,55,D5,12,34 with dv -> one cycle later each cycle: rise/fall = 5/5, 5/5, 5/D, 2/1, 4/3; ctl_rise = 1, ctl_fall = 1; all 0 the cycle after the last byte.
- MII frame: mii_select = 1, MAC holds each byte until rdy, bytes 12,34 -> txd sequence 2,1,4,3 (rise == fall); rdy pattern 1,0,1,0,1; 4 cycles ctl high.
- MII error byte: byte 8'hFF with er = 1 -> both nibble cycles ctl_rise = 1, ctl_fall = 0; with RGMII_TX_STATS_EN defined, stat_err_cnt = 1 and stat_frame_cnt = 1.
- Mode change mid-frame: toggle mii_select 0 -> 1 during a gigabit frame -> frame completes in gigabit; next frame uses MII nibble timing.
- Reset mid-MII-byte: assert reset_n low in MII_LO -> outputs 0 on that edge; no high nibble emitted after release.

Source files
------------

// File: rtl/rgmii_tx_nibble_if.sv
// rgmii_tx_nibble_if: converts the TX MAC byte stream into per-edge RGMII
// nibbles and TX_CTL values for the external DDR output registers.
// Gigabit mode sends a full byte per cycle. MII (10/100) mode sends one byte
// every two cycles, low nibble first, and throttles the MAC through rdy.
// Optional statistics counters are enabled by defining RGMII_TX_STATS_EN.
module rgmii_tx_nibble_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NIB_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] rgmii_mac_tx_data,
    input  logic                  rgmii_mac_tx_dv,
    input  logic                  rgmii_mac_tx_er,
    input  logic                  mii_select,
    output logic                  rgmii_mac_tx_rdy,
    output logic [NIB_WIDTH-1:0]  rgmii_txd_rise,
    output logic [NIB_WIDTH-1:0]  rgmii_txd_fall,
    output logic                  rgmii_tx_ctl_rise,
    output logic                  rgmii_tx_ctl_fall
`ifdef RGMII_TX_STATS_EN
    ,
    output logic [31:0]           stat_frame_cnt,
    output logic [31:0]           stat_byte_cnt,
    output logic [15:0]           stat_err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, GIG, MII_LO, MII_HI} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_er_q, hold_er_d;
    logic                  rdy_q, rdy_d;
    logic [NIB_WIDTH-1:0]  txd_rise_q, txd_rise_d;
    logic [NIB_WIDTH-1:0]  txd_fall_q, txd_fall_d;
    logic                  ctl_rise_q, ctl_rise_d;
    logic                  ctl_fall_q, ctl_fall_d;
    logic                  accept;

    assign accept = rdy_q & rgmii_mac_tx_dv;

    // Next state, mode latch, byte capture and the next registered outputs.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        hold_data_d = hold_data_q;
        hold_er_d   = hold_er_q;
        txd_rise_d  = '0;
        txd_fall_d  = '0;
        ctl_rise_d  = 1'b0;
        ctl_fall_d  = 1'b0;

        if (state_q == IDLE && !rgmii_mac_tx_dv) begin
            mode_d = mii_select;
        end

        if (accept) begin
            hold_data_d = rgmii_mac_tx_data;
            hold_er_d   = rgmii_mac_tx_er;
        end

        case (state_q)
            IDLE:    if (accept) state_d = mode_q ? MII_LO : GIG;
            GIG:     state_d = accept ? GIG : IDLE;
            MII_LO:  state_d = MII_HI;
            MII_HI:  state_d = accept ? MII_LO : IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            GIG: begin
                txd_rise_d = rgmii_mac_tx_data[NIB_WIDTH-1:0];
                txd_fall_d = rgmii_mac_tx_data[DATA_WIDTH-1:NIB_WIDTH];
                ctl_rise_d = 1'b1;
                ctl_fall_d = ~rgmii_mac_tx_er;
            end
            MII_LO: begin
                txd_rise_d = hold_data_d[NIB_WIDTH-1:0];
                txd_fall_d = hold_data_d[NIB_WIDTH-1:0];
                ctl_rise_d = 1'b1;
                ctl_fall_d = ~hold_er_d;
            end
            MII_HI: begin
                txd_rise_d = hold_data_d[DATA_WIDTH-1:NIB_WIDTH];
                txd_fall_d = hold_data_d[DATA_WIDTH-1:NIB_WIDTH];
                ctl_rise_d = 1'b1;
                ctl_fall_d = ~hold_er_d;
            end
            default: begin
                ctl_fall_d = !mode_q && rgmii_mac_tx_er && !rgmii_mac_tx_dv;
            end
        endcase

        rdy_d = (state_d != MII_LO);
    end

    // State, mode, hold and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            hold_data_q <= '0;
            hold_er_q   <= 1'b0;
            rdy_q       <= 1'b0;
            txd_rise_q  <= '0;
            txd_fall_q  <= '0;
            ctl_rise_q  <= 1'b0;
            ctl_fall_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            hold_data_q <= hold_data_d;
            hold_er_q   <= hold_er_d;
            rdy_q       <= rdy_d;
            txd_rise_q  <= txd_rise_d;
            txd_fall_q  <= txd_fall_d;
            ctl_rise_q  <= ctl_rise_d;
            ctl_fall_q  <= ctl_fall_d;
        end
    end

    assign rgmii_mac_tx_rdy  = rdy_q;
    assign rgmii_txd_rise    = txd_rise_q;
    assign rgmii_txd_fall    = txd_fall_q;
    assign rgmii_tx_ctl_rise = ctl_rise_q;
    assign rgmii_tx_ctl_fall = ctl_fall_q;

`ifdef RGMII_TX_STATS_EN
    logic        in_frame_q, in_frame_d;
    logic        frame_err_q, frame_err_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Frame tracking: a frame ends when dv is low at a point where rdy is high.
    always_comb begin
        in_frame_d  = in_frame_q;
        frame_err_d = frame_err_q;
        frame_cnt_d = frame_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            in_frame_d  = 1'b1;
            frame_err_d = frame_err_q | rgmii_mac_tx_er;
            byte_cnt_d  = byte_cnt_q + 32'd1;
        end else if (rdy_q && !rgmii_mac_tx_dv && in_frame_q) begin
            in_frame_d  = 1'b0;
            frame_err_d = 1'b0;
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (frame_err_q) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // Statistics registers, cleared by reset and wrapping on overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_frame_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            in_frame_q  <= in_frame_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign stat_frame_cnt = frame_cnt_q;
    assign stat_byte_cnt  = byte_cnt_q;
    assign stat_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_rgmii_tx_nibble_if.sv
// Directed bench for rgmii_tx_nibble_if: reset, gigabit frame, MII frames,
// error byte, mid-frame mode change and reset in the middle of an MII byte.
// Statistics checks are compiled in when RGMII_TX_STATS_EN is defined.
module tb_rgmii_tx_nibble_if;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_dv;
    logic       tx_er;
    logic       mii_select;
    logic       tx_rdy;
    logic [3:0] txd_rise;
    logic [3:0] txd_fall;
    logic       ctl_rise;
    logic       ctl_fall;
`ifdef RGMII_TX_STATS_EN
    logic [31:0] stat_frame_cnt;
    logic [31:0] stat_byte_cnt;
    logic [15:0] stat_err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    rgmii_tx_nibble_if dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rgmii_mac_tx_data (tx_data),
        .rgmii_mac_tx_dv   (tx_dv),
        .rgmii_mac_tx_er   (tx_er),
        .mii_select        (mii_select),
        .rgmii_mac_tx_rdy  (tx_rdy),
        .rgmii_txd_rise    (txd_rise),
        .rgmii_txd_fall    (txd_fall),
        .rgmii_tx_ctl_rise (ctl_rise),
        .rgmii_tx_ctl_fall (ctl_fall)
`ifdef RGMII_TX_STATS_EN
        ,
        .stat_frame_cnt    (stat_frame_cnt),
        .stat_byte_cnt     (stat_byte_cnt),
        .stat_err_cnt      (stat_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive MAC inputs, then move to 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic dv, input logic [7:0] data, input logic er);
        tx_dv   = dv;
        tx_data = data;
        tx_er   = er;
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the packed output bundle {rdy, rise, fall, ctl_rise, ctl_fall}.
    task automatic checkOutput(input string tag, input logic rdy, input logic [3:0] rise,
                               input logic [3:0] fall, input logic cr, input logic cf);
        checkValue(tag, {21'd0, tx_rdy, txd_rise, txd_fall, ctl_rise, ctl_fall},
                        {21'd0, rdy, rise, fall, cr, cf});
    endtask

    initial begin
        logic [7:0] gig_bytes [5];
        logic [3:0] gig_rise  [5];
        logic [3:0] gig_fall  [5];
        gig_bytes = '{8'h55, 8'h55, 8'hD5, 8'h12, 8'h34};
        gig_rise  = '{4'h5, 4'h5, 4'h5, 4'h2, 4'h4};
        gig_fall  = '{4'h5, 4'h5, 4'hD, 4'h1, 4'h3};

        reset_n    = 1'b0;
        mii_select = 1'b0;
        tx_dv      = 1'b1;
        tx_data    = 8'hA5;
        tx_er      = 1'b0;

        // Reset held three cycles with a valid byte presented.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        end
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rdy_after_release", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);

        // Gigabit frame.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, gig_bytes[i], 1'b0);
            checkOutput("gig_byte", 1'b1, gig_rise[i], gig_fall[i], 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("gig_end", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);

        // MII frame 12,34 with the MAC holding each byte until rdy.
        mii_select = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mii_idle", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h12, 1'b0);
        checkOutput("mii_b0_lo", 1'b0, 4'h2, 4'h2, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h34, 1'b0);
        checkOutput("mii_b0_hi", 1'b1, 4'h1, 4'h1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h34, 1'b0);
        checkOutput("mii_b1_lo", 1'b0, 4'h4, 4'h4, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mii_b1_hi", 1'b1, 4'h3, 4'h3, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mii_end", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);

        // MII error byte.
        applyStimulus(1'b1, 8'hFF, 1'b1);
        checkOutput("mii_err_lo", 1'b0, 4'hF, 4'hF, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mii_err_hi", 1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("mii_err_end", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef RGMII_TX_STATS_EN
        checkValue("stat_frames_a", stat_frame_cnt, 32'd3);
        checkValue("stat_bytes_a", stat_byte_cnt, 32'd8);
        checkValue("stat_errs_a", {16'd0, stat_err_cnt}, 32'd1);
`endif

        // Back to gigabit; carrier extend with dv low and er high.
        mii_select = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("mode_back_mii_idle", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("carrier_extend", 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);

        // Mode change in the middle of a gigabit frame.
        applyStimulus(1'b1, 8'hAB, 1'b0);
        checkOutput("chg_gig_b0", 1'b1, 4'hB, 4'hA, 1'b1, 1'b1);
        mii_select = 1'b1;
        applyStimulus(1'b1, 8'hCD, 1'b1);
        checkOutput("chg_gig_b1_err", 1'b1, 4'hD, 4'hC, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("chg_gig_end", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("chg_idle", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h9E, 1'b0);
        checkOutput("chg_mii_lo", 1'b0, 4'hE, 4'hE, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("chg_mii_hi", 1'b1, 4'h9, 4'h9, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("chg_mii_end", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef RGMII_TX_STATS_EN
        checkValue("stat_frames_b", stat_frame_cnt, 32'd5);
        checkValue("stat_bytes_b", stat_byte_cnt, 32'd11);
        checkValue("stat_errs_b", {16'd0, stat_err_cnt}, 32'd2);
`endif

        // Reset while the low nibble of an MII byte is on the wire.
        applyStimulus(1'b1, 8'h7C, 1'b0);
        checkOutput("rst_mii_lo", 1'b0, 4'hC, 4'hC, 1'b1, 1'b1);
        reset_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rst_mid_byte", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef RGMII_TX_STATS_EN
        checkValue("stat_frames_rst", stat_frame_cnt, 32'd0);
        checkValue("stat_bytes_rst", stat_byte_cnt, 32'd0);
`endif
        reset_n = 1'b1;
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("rst_release", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("rst_mode_cleared", 1'b1, 4'hA, 4'h5, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rst_final_idle", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
